// File: rtl/capture_controller_pkg.sv
// Shared definitions for the sample-capture controller.
//   state_e          : controller state encoding
//   GROUP_SUFFIX     : low bits appended to a group count (counts are in groups of 4)
//   terminal_count() : builds the 18-bit terminal value for a 16-bit group count
package capture_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_DELAY,
    ST_READ,
    ST_READWAIT
  } state_e;

  localparam int unsigned CNT_W        = 18;
  localparam logic [1:0]  GROUP_SUFFIX = 2'b11;

  // A group count of N means N*4+4 samples, so the last index is {N, 2'b11}.
  function automatic logic [CNT_W-1:0] terminal_count(input logic [15:0] groups);
    return {groups, GROUP_SUFFIX};
  endfunction

endpackage

// File: rtl/capture_controller.sv
// Capture controller: writes samples into the sample memory while armed,
// continues for a programmed number of post-trigger samples once run fires,
// then reads a programmed number of words back and hands each to the
// transmitter.
//
// Ports
//   clock            : sole clock, rising edge
//   reset            : synchronous, active-high
//   run / arm        : delay-aligned trigger and arm pulses
//   wrSize/wrFwd/wrBwd, config_data : load post-trigger (fwd) / read-back (bwd) counts
//   validIn, dataIn  : incoming sample stream
//   busy             : transmitter cannot accept a word
//   send             : one-cycle transmit request
//   memoryWrData     : dataIn delayed by one clock
//   memoryRead       : one-cycle memory read strobe
//   memoryWrite      : one-cycle memory write strobe
//   memoryLastWrite  : marks the final write of a capture
module capture_controller
  import capture_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        arm,
  input  logic        wrSize,
  input  logic        wrFwd,
  input  logic        wrBwd,
  input  logic [31:0] config_data,
  input  logic        validIn,
  input  logic [31:0] dataIn,
  input  logic        busy,
  output logic        send,
  output logic [31:0] memoryWrData,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic        memoryLastWrite
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [15:0]      fwd_q, fwd_d;
  logic [15:0]      bwd_q, bwd_d;
  logic             send_q, send_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             last_write_q, last_write_d;
  logic [31:0]      wr_data_q, wr_data_d;

  // Configuration registers, independent of the capture state.
  always_comb begin
    fwd_d = fwd_q;
    bwd_d = bwd_q;
    if (wrSize) begin
      fwd_d = config_data[31:16];
      bwd_d = config_data[15:0];
    end else if (wrFwd) begin
      fwd_d = config_data[15:0];
    end else if (wrBwd) begin
      bwd_d = config_data[15:0];
    end
  end

  // NOTE: every signal assigned here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    send_d       = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    last_write_d = 1'b0;
    wr_data_d    = dataIn;

    unique case (state_q)
      ST_IDLE: begin
        counter_d   = '0;
        mem_write_d = 1'b1;
        if (run)      state_d = ST_DELAY;
        else if (arm) state_d = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        counter_d   = '0;
        mem_write_d = validIn;
        if (run) state_d = ST_DELAY;
      end

      ST_DELAY: begin
        if (validIn) begin
          mem_write_d = 1'b1;
          if (counter_q == terminal_count(fwd_q)) begin
            last_write_d = 1'b1;
            counter_d    = '0;
            state_d      = ST_READ;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end

      ST_READ: begin
        mem_read_d = 1'b1;
        send_d     = 1'b1;
        if (counter_q == terminal_count(bwd_q)) begin
          counter_d = '0;
          state_d   = ST_IDLE;
        end else begin
          counter_d = counter_q + 1'b1;
          state_d   = ST_READWAIT;
        end
      end

      ST_READWAIT: begin
        // The registered send from the previous READ must have dropped before
        // the next word is requested, guaranteeing a gap between requests.
        if (!busy && !send_q) state_d = ST_READ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      fwd_q        <= '0;
      bwd_q        <= '0;
      send_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      last_write_q <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      fwd_q        <= fwd_d;
      bwd_q        <= bwd_d;
      send_q       <= send_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      last_write_q <= last_write_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign send            = send_q;
  assign memoryRead      = mem_read_q;
  assign memoryWrite     = mem_write_q;
  assign memoryLastWrite = last_write_q;
  assign memoryWrData    = wr_data_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: reset values, sample/trigger flow,
// post-trigger write count, read-back pacing with busy, data delay, run/arm
// priority, config priority and mid-capture reset.
module tb_capture_controller;

  logic        clock = 1'b0;
  logic        reset, run, arm, wrSize, wrFwd, wrBwd, validIn, busy;
  logic [31:0] config_data, dataIn;
  logic        send, memoryRead, memoryWrite, memoryLastWrite;
  logic [31:0] memoryWrData;

  int total = 0;
  int bad   = 0;

  capture_controller dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .arm            (arm),
    .wrSize         (wrSize),
    .wrFwd          (wrFwd),
    .wrBwd          (wrBwd),
    .config_data    (config_data),
    .validIn        (validIn),
    .dataIn         (dataIn),
    .busy           (busy),
    .send           (send),
    .memoryWrData   (memoryWrData),
    .memoryRead     (memoryRead),
    .memoryWrite    (memoryWrite),
    .memoryLastWrite(memoryLastWrite)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Starts in DELAY; alternates valid/idle cycles, counts writes until the
  // last-write marker or the cycle budget runs out.
  task automatic post_trigger(input string tag, input int exp_writes);
    int  writes = 0;
    bit  done   = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      validIn = ((i % 3) != 2);
      tick();
      if (memoryWrite) writes++;
      if (memoryLastWrite) begin
        done = 1;
        check({tag, "_last_with_write"}, {31'd0, memoryWrite}, 32'd1);
      end
    end
    validIn = 1'b0;
    check({tag, "_last_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_write_count"}, writes, exp_writes);
  endtask

  // Counts send pulses until IDLE reappears (write strobe every cycle).
  task automatic readout(input string tag, input int exp_sends);
    int sends = 0;
    int reads = 0;
    bit idle  = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      tick();
      if (send) sends++;
      if (memoryRead) reads++;
      if (memoryWrite) idle = 1;
    end
    check({tag, "_back_to_idle"}, {31'd0, idle}, 32'd1);
    check({tag, "_send_count"}, sends, exp_sends);
    check({tag, "_read_count"}, reads, exp_sends);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; arm = 1'b0; wrSize = 1'b0; wrFwd = 1'b0; wrBwd = 1'b0;
    validIn = 1'b0; busy = 1'b0; config_data = '0; dataIn = 32'hFFFF_FFFF;

    // Reset state
    tick(); tick();
    check("rst_send", {31'd0, send}, 32'd0);
    check("rst_read", {31'd0, memoryRead}, 32'd0);
    check("rst_write", {31'd0, memoryWrite}, 32'd0);
    check("rst_last", {31'd0, memoryLastWrite}, 32'd0);
    check("rst_wrdata", memoryWrData, 32'd0);

    // IDLE writes every cycle; load fwd=1, bwd=0 meanwhile
    reset = 1'b0; wrSize = 1'b1; config_data = 32'h0001_0000; dataIn = 32'hDEAD_BEEF;
    tick();
    wrSize = 1'b0; dataIn = 32'h0;
    check("idle_write", {31'd0, memoryWrite}, 32'd1);
    check("wrdata_idle", memoryWrData, 32'hDEAD_BEEF);

    // Arm, then SAMPLE writes only when validIn
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    check("sample_novalid", {31'd0, memoryWrite}, 32'd0);
    validIn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("sample_valid_write", {31'd0, memoryWrite}, 32'd1);
    end
    check("sample_no_last", {31'd0, memoryLastWrite}, 32'd0);

    // Trigger: fwd=1 -> 8 post-trigger writes, then bwd=0 -> 4 sends
    run = 1'b1;
    tick();
    run = 1'b0;
    post_trigger("cap1", 8);
    readout("cap1", 4);

    // Config priority: wrSize beats wrFwd/wrBwd -> fwd=0, bwd=1
    wrSize = 1'b1; wrFwd = 1'b1; wrBwd = 1'b1; config_data = 32'h0000_0001;
    tick();
    wrSize = 1'b0; wrFwd = 1'b0; wrBwd = 1'b0; config_data = 32'hFFFF_FFFF;

    // run and arm together in IDLE -> straight to DELAY (last write after 4)
    run = 1'b1; arm = 1'b1;
    tick();
    run = 1'b0; arm = 1'b0;
    post_trigger("cap2", 4);

    // Read-back paced by busy
    tick();
    check("cap2_first_send", {31'd0, send}, 32'd1);
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("busy_no_send", {31'd0, send}, 32'd0);
    end
    busy = 1'b0;
    tick();
    check("release_readwait", {31'd0, send}, 32'd0);
    tick();
    check("release_send", {31'd0, send}, 32'd1);
    readout("cap2", 6);

    // Mid-capture reset after 3 writes in DELAY
    wrSize = 1'b1; config_data = 32'h0002_0003;
    tick();
    wrSize = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0; validIn = 1'b1; dataIn = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("delay_write", {31'd0, memoryWrite}, 32'd1);
    end
    check("wrdata_delay", memoryWrData, 32'h1234_5678);
    validIn = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_write", {31'd0, memoryWrite}, 32'd0);
    check("midrst_last", {31'd0, memoryLastWrite}, 32'd0);
    check("midrst_send", {31'd0, send}, 32'd0);
    check("midrst_wrdata", memoryWrData, 32'd0);
    tick();
    check("midrst_idle_write", {31'd0, memoryWrite}, 32'd1);
    check("midrst_idle_send", {31'd0, send}, 32'd0);

    // fwd=bwd=0 after reset: 4 writes, 4 sends
    run = 1'b1;
    tick();
    run = 1'b0;
    post_trigger("cap3", 4);
    readout("cap3", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 Parameters: none; counter and register widths are fixed by this document.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  trigger-fired pulse, already delay-aligned by the core.
REQ-005 arm  input  1  arm pulse, already delay-aligned by the core.
REQ-006 wrSize  input  1  load both sample counts from config_data.
REQ-007 wrFwd  input  1  load post-trigger count from config_data.
REQ-008 wrBwd  input  1  load read-back count from config_data.
REQ-009 config_data  input  32  configuration word.
REQ-010 validIn  input  1  dataIn is a valid sample this cycle.
REQ-011 dataIn  input  32  sample, RLE-encoded if enabled.
REQ-012 busy  input  1  transmitter cannot accept a word.
REQ-013 send  output  1  one-cycle request to transmit the word being read.
REQ-014 memoryWrData  output  32  dataIn registered by one clock, unconditionally.
REQ-015 memoryRead  output  1  one-cycle sample-memory read strobe.
REQ-016 memoryWrite  output  1  one-cycle sample-memory write strobe.
REQ-017 memoryLastWrite  output  1  marks the final write of a capture.

Function
REQ-018 Registers: fwd[15:0], bwd[15:0]; wrSize loads fwd=config_data[31:16], bwd=config_data[15:0]; wrFwd loads fwd=config_data[15:0]; wrBwd loads bwd=config_data[15:0]; priority wrSize > wrFwd > wrBwd; registers hold otherwise.
REQ-019 Counts are in groups of 4 samples; terminal values are {fwd,2'b11} and {bwd,2'b11}; counter is 18 bits and never wraps.
REQ-020 All outputs are registered; each strobe (send, memoryRead, memoryWrite, memoryLastWrite) defaults to 0 every cycle unless a state below sets it.
REQ-021 States: IDLE, SAMPLE, DELAY, READ, READWAIT.
REQ-022 IDLE: counter=0; memoryWrite=1 every cycle; run -> DELAY; else arm -> SAMPLE.
REQ-023 SAMPLE: counter=0; memoryWrite=validIn; run -> DELAY; arm is ignored.
REQ-024 DELAY: on validIn, memoryWrite=1 and counter+1; when validIn and counter=={fwd,2'b11}, memoryLastWrite=1, counter=0, go to READ; validIn=0 holds state and counter.
REQ-025 READ: memoryRead=1 and send=1 for one cycle; if counter=={bwd,2'b11}, counter=0 and go to IDLE; else counter+1 and go to READWAIT.
REQ-026 READWAIT: go to READ only when busy=0 and send=0; otherwise wait.
REQ-027 run and arm in the same IDLE cycle: run wins.
REQ-028 run, arm and wr* commands during DELAY/READ/READWAIT do not change state; wr* updates fwd/bwd immediately and affects the terminal compare.
REQ-029 Total: fwd*4+4 post-trigger writes, including the last write; bwd*4+4 read/send pulses per capture.

Reset
REQ-030 reset: state=IDLE, counter=0, send=memoryRead=memoryWrite=memoryLastWrite=0, memoryWrData=0, fwd=bwd=0.
REQ-031 reset asserted mid-capture or mid-readout aborts on the next edge; no further strobes until re-run.

Structure
REQ-032 State encoding enum and the 2-bit group-count suffix constant belong in the shared core package.
REQ-033 Single module, one registered always block plus one combinational next-state block; no sub-modules.

Verification
REQ-034 wrSize config_data=0x0001_0000, arm, 20 validIn, run -> exactly 8 post-trigger memoryWrite pulses, memoryLastWrite on the 8th, then READ.
REQ-035 bwd=0, busy=0 -> 4 send/memoryRead pulses, each separated by READWAIT cycles, then IDLE.
REQ-036 busy held 1 during READWAIT for 10 cycles -> no send; release -> send on the next READ cycle.
REQ-037 dataIn=0xDEADBEEF at cycle n -> memoryWrData=0xDEADBEEF at cycle n+1 in any state.
REQ-038 run and arm in the same IDLE cycle -> DELAY entered, SAMPLE skipped.
REQ-039 reset pulse in DELAY after 3 writes -> IDLE, all strobes 0, fwd=bwd=0.
